// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit: fetch entries,
// the derived fetch mode and the debug view of the fetch counters.
package instr_fetch_unit_pkg;

  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
  localparam int          INSTR_BYTES = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // DRAIN means stale responses from before a redirect are still due.
  typedef enum logic {
    MODE_RUN   = 1'b0,
    MODE_DRAIN = 1'b1
  } fetch_mode_e;

  typedef struct packed {
    fetch_mode_e mode;
    logic [7:0]  outstanding;
    logic [7:0]  drop_cnt;
    logic [7:0]  fifo_count;
  } fetch_dbg_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bus bundle between the fetch unit (master), instruction memory and decode.
// Handshakes: a transfer happens on a rising clk edge where valid and ready are
// both high; valid never waits on ready, and redirect_valid is a one-cycle pulse.
interface instr_fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  modport master (
    output imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    input  redirect_valid, redirect_pc, if_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    output redirect_valid, redirect_pc, if_ready
  );
endinterface

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Prefetch FIFO of {pc, instr} entries; flush empties it in one cycle and
// wins over push/pop. DEPTH must be a power of two so the pointers wrap freely.
module fetch_fifo
  import instr_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push,
  input  logic                           pop,
  input  logic                           flush,
  input  fetch_entry_t                   push_data,
  output fetch_entry_t                   head,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           empty,
  output logic                           full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic           do_push;
  logic           do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: an entry is only visible once count covers it.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: issues word-aligned reads under a credit limit,
// buffers in-order responses and hands {pc, instr} to decode; redirects flush.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  instr_fetch_unit_if.master     bus,
  output fetch_dbg_t             dbg
);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [31:0]   fetch_pc;
  logic [31:0]   next_resp_pc;
  logic [31:0]   last_pc;
  logic [OW-1:0] outstanding;
  logic [OW-1:0] outstanding_after_resp;
  logic [OW-1:0] drop_cnt;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic          fifo_full;
  logic          can_issue;
  logic          req_fire;
  logic          push;
  logic          pop;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;

  // Counting buffered plus in-flight words against the FIFO depth means a
  // response can always be pushed, so memory never needs back-pressure.
  assign can_issue = (32'(outstanding) + 32'(fifo_count) < 32'(FIFO_DEPTH)) &&
                     (32'(outstanding) < 32'(MAX_OUTSTANDING));

  assign bus.imem_req_valid = rst_n && !bus.redirect_valid && can_issue;
  assign bus.imem_req_addr  = fetch_pc;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

  assign outstanding_after_resp = outstanding - OW'(bus.imem_resp_valid);
  assign push       = bus.imem_resp_valid && !bus.redirect_valid && (drop_cnt == '0);
  assign push_entry = '{pc: next_resp_pc, instr: bus.imem_resp_data};

  assign bus.if_valid = !fifo_empty && !bus.redirect_valid;
  assign pop          = bus.if_valid && bus.if_ready;
  assign bus.if_pc    = bus.if_valid ? head.pc : last_pc;
  assign bus.if_instr = bus.if_valid ? head.instr : NOP_INSTR;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc     <= RESET_PC;
      next_resp_pc <= RESET_PC;
      outstanding  <= '0;
      drop_cnt     <= '0;
      last_pc      <= '0;
    end else begin
      outstanding <= outstanding_after_resp + OW'(req_fire);
      if (bus.if_valid) last_pc <= head.pc;
      if (bus.redirect_valid) begin
        fetch_pc     <= align_pc(bus.redirect_pc);
        next_resp_pc <= align_pc(bus.redirect_pc);
        drop_cnt     <= outstanding_after_resp;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'(INSTR_BYTES);
        if (bus.imem_resp_valid) begin
          if (drop_cnt != '0) drop_cnt     <= drop_cnt - 1'b1;
          else                next_resp_pc <= next_resp_pc + 32'(INSTR_BYTES);
        end
      end
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .flush     (bus.redirect_valid),
    .push_data (push_entry),
    .head      (head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign dbg.mode        = (drop_cnt != '0) ? MODE_DRAIN : MODE_RUN;
  assign dbg.outstanding = 8'(outstanding);
  assign dbg.drop_cnt    = 8'(drop_cnt);
  assign dbg.fifo_count  = 8'(fifo_count);

  a_out_max:    assert property (@(posedge clk) disable iff (!rst_n)
                  32'(outstanding) <= 32'(MAX_OUTSTANDING));
  a_credit:     assert property (@(posedge clk) disable iff (!rst_n)
                  32'(outstanding) + 32'(fifo_count) <= 32'(FIFO_DEPTH));
  a_drop_le:    assert property (@(posedge clk) disable iff (!rst_n) drop_cnt <= outstanding);
  a_resp_owed:  assert property (@(posedge clk) disable iff (!rst_n)
                  bus.imem_resp_valid |-> (outstanding != '0));
  a_push_room:  assert property (@(posedge clk) disable iff (!rst_n) push |-> !fifo_full);

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Initiator side of the instruction-memory read interface.
- Holds the PC and issues word-aligned read requests to instruction memory.
- Buffers in-order responses in a small prefetch FIFO and hands {pc, instr} to decode through a valid/ready handshake.
- Handles redirects from branches and jumps (BLT/BEQ/JAL/JALR) by flushing buffered instructions and discarding in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset; bits [1:0] must be 0.
- FIFO_DEPTH, 4, prefetch entries; power of two, ≥2.
- MAX_OUTSTANDING, 4, maximum requests accepted but not yet answered.

Ports:
- clk  in  1  clock; everything is posedge.
- rst_n  in  1  async active-low reset.
- imem_req_valid  out  1  read request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  32  byte address, bits [1:0] always 00.
- imem_resp_valid  in  1  read data valid, in request order.
- imem_resp_data  in  32  instruction word.
- redirect_valid  in  1  flush and restart fetch.
- redirect_pc  in  32  new PC; bits [1:0] ignored (treated as 00).
- if_valid  out  1  fetched instruction available.
- if_ready  in  1  decode consumes the instruction.
- if_pc  out  32  PC of the presented instruction.
- if_instr  out  32  presented instruction word.

Behaviour:
- Reset, asynchronous on rst_n low:
  - fetch_pc = next_resp_pc = RESET_PC; outstanding = 0; drop_cnt = 0; FIFO empty.
  - imem_req_valid = 0, if_valid = 0, if_pc = 0, if_instr = 32'h00000013.
  - Reset mid-transfer abandons all in-flight requests.
  - Memory must not return responses for pre-reset requests.
- Issue:
  - imem_req_valid = !redirect_valid && (outstanding + fifo_count < FIFO_DEPTH) && (outstanding < MAX_OUTSTANDING).
  - imem_req_addr = fetch_pc.
  - On req_valid && req_ready: fetch_pc += 4 (wraps at 2^32), outstanding += 1.
  - The credit rule guarantees a response never finds the FIFO full.
- Response:
  - Arrives no earlier than the cycle after acceptance.
  - Each imem_resp_valid decrements outstanding; issue and response in the same cycle net to 0.
  - If drop_cnt > 0: data discarded, drop_cnt -= 1.
  - Otherwise {next_resp_pc, imem_resp_data} is pushed to the FIFO and next_resp_pc += 4.
- Output:
  - if_valid = fifo_not_empty && !redirect_valid; if_pc/if_instr = FIFO head.
  - Pop on if_valid && if_ready.
  - When if_valid = 0, if_instr = NOP (32'h00000013), if_pc holds its last value.
  - Push and pop in the same cycle keep the count unchanged; zero-bubble streaming at full rate with 1-cycle memory latency.
- Redirect (single-cycle pulse, takes priority over everything):
  - Same cycle: no request issued, no pop, any arriving response discarded.
  - Next edge: FIFO cleared; fetch_pc = next_resp_pc = {redirect_pc[31:2],2'b00}; drop_cnt = outstanding_after_this_cycle (current outstanding minus any response arriving this cycle).
  - First new request issues the cycle after the redirect, even while drop_cnt > 0 (responses stay ordered).
  - Back-to-back redirects: the last one wins; drop_cnt is recomputed each time.
- Invariants (verified by assertions):
  - outstanding ≤ MAX_OUTSTANDING.
  - outstanding + fifo_count ≤ FIFO_DEPTH.
  - drop_cnt ≤ outstanding.
  - A response when outstanding == 0 is an error.
- No state machine beyond the counters. The fetch mode (RUN vs DRAIN, where drop_cnt > 0) is derived, not encoded.

Decomposition:
- Additions to package riscv_structures:
  - typedef fetch_entry_t {logic [31:0] pc; logic [31:0] instr;}
  - localparam NOP_INSTR = 32'h00000013
  - localparam INSTR_BYTES = 4
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t, parameter DEPTH, ports push/pop/flush/count/head, async active-low reset.

Test Plan:
- Reset, memory with 1-cycle latency, if_ready = 1 -> requests at 0x0, 0x4, 0x8… every cycle; decode sees pc 0x0 instr 0x00100093, then 0x4/0x00200113, 0x8/0x0020c463, one per cycle after a 2-cycle startup.
- if_ready = 0 for 10 cycles -> FIFO holds exactly 4 entries; imem_req_valid drops once outstanding + count = 4; no response lost when if_ready returns.
- Memory latency 3 cycles, 3 requests outstanding, redirect_pc = 0x10 -> the 3 old responses are discarded; first delivered entry is pc 0x10 instr 0x00400213.
- Redirect in the same cycle as a response for pc 0xC -> that response is dropped and drop_cnt = outstanding − 1; next delivered pc equals redirect_pc.
- redirect_pc = 0x13 -> fetch starts at 0x10; if_pc = 0x10.
- rst_n pulsed low mid-stream with 2 outstanding -> all outputs return to reset values immediately (asynchronously); fetch restarts at RESET_PC.
